// File: rtl/seq_alu_param.sv
// seq_alu_param: a multi-cycle, width-parametrised ALU with a start/done handshake.
// Logic, compare, add and subtract operations finish one cycle after they are
// accepted. MOD uses a restoring divider that handles one dividend bit per
// cycle, then spends one finishing cycle restoring the sign of the remainder.
module seq_alu_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Registered outputs and divider working registers
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic             dbz_q, dbz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder, always < divisor
  logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dvs_q, dvs_d;    // divisor magnitude
  logic             neg_q, neg_d;    // remainder must be negated at FIN

  // Single-cycle ALU datapath
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             is_mod;
  logic             b_zero;

  // Divider step
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_step;

  // Combinational single-cycle ALU operations and operand magnitudes
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    slt_bit = signed_mode ? ($signed(a) < $signed(b)) : (a < b);

    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (select)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOR: alu_res = ~(a | b);
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = signed_mode & add_ovf;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = signed_mode & sub_ovf;
      end
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase

    // Most-negative value negates to itself, which as an unsigned number is
    // exactly its magnitude 2^(WIDTH-1), so no special case is needed.
    a_neg  = signed_mode & a[WIDTH-1];
    b_neg  = signed_mode & b[WIDTH-1];
    a_mag  = a_neg ? (ZERO_W - a) : a;
    b_mag  = b_neg ? (ZERO_W - b) : b;
    is_mod = (select == OP_MOD);
    b_zero = (b == ZERO_W);
  end

  // One restoring-division step: bring in the next dividend bit, subtract if it fits
  always_comb begin
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    rem_ge    = (rem_shift >= {1'b0, dvs_q});
    rem_step  = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: only a MOD with a non-zero divisor leaves IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && is_mod && !b_zero) begin
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values for each state
  always_comb begin
    result_d   = result_q;
    done_d     = 1'b0;
    overflow_d = 1'b0;
    dbz_d      = 1'b0;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    neg_d      = neg_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!is_mod) begin
            result_d   = alu_res;
            overflow_d = alu_ovf;
            done_d     = 1'b1;
          end else if (b_zero) begin
            result_d = a;
            dbz_d    = 1'b1;
            done_d   = 1'b1;
          end else begin
            dvd_d = a_mag;
            dvs_d = b_mag;
            neg_d = a_neg;
            rem_d = '0;
            cnt_d = CNT_FULL;
          end
        end
      end
      S_DIV: begin
        rem_d = rem_step;
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q - CNT_ONE;
      end
      S_FIN: begin
        // Remainder takes the sign of the dividend
        result_d = neg_q ? (ZERO_W - rem_q) : rem_q;
        done_d   = 1'b1;
      end
      default: begin
        result_d = result_q;
      end
    endcase
  end

  // Datapath and output registers; reset aborts any operation without a done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q   <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      dbz_q      <= 1'b0;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      neg_q      <= 1'b0;
    end else begin
      result_q   <= result_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      dbz_q      <= dbz_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      neg_q      <= neg_d;
    end
  end

  assign result      = result_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != S_IDLE);

endmodule
